// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer for the 9-bit ISA core.
// Drives the instruction ROM address, runs the Start handshake,
// flags Done at halt and counts executed RUN cycles.
module fetch_pc #(
  parameter int unsigned A  = 10,
  parameter int unsigned OW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Taken,
  input  logic          AbsSel,
  input  logic [A-1:0]  Target,
  input  logic [OW-1:0] RelOff,
  output logic [A-1:0]  InstAddress,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [A-1:0]  pc_nx;
  logic [CW-1:0] ct_nx;
  logic [A-1:0]  rel_ext;
  logic [CW-1:0] ct_inc;

  // Sign-extended relative offset and saturating cycle increment
  always_comb begin
    rel_ext = A'($signed(RelOff));
    ct_inc  = (CycleCt == {CW{1'b1}}) ? CycleCt : CycleCt + CW'(1);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, next PC and next cycle count
  always_comb begin
    state_nx = state;
    pc_nx    = InstAddress;
    ct_nx    = CycleCt;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nx = S_ARMED;
          pc_nx    = '0;
          ct_nx    = '0;
        end
      end
      S_ARMED: begin
        pc_nx = '0;
        if (!Start) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (Start) begin
          state_nx = S_ARMED;
          pc_nx    = '0;
          ct_nx    = '0;
        end else begin
          ct_nx = ct_inc;
          if (Halt) begin
            state_nx = S_DONE;
          end else if (Stall) begin
            pc_nx = InstAddress;
          end else if (Taken) begin
            pc_nx = AbsSel ? Target : InstAddress + rel_ext;
          end else begin
            pc_nx = InstAddress + A'(1);
          end
        end
      end
      S_DONE: begin
        if (Start) begin
          state_nx = S_ARMED;
          pc_nx    = '0;
          ct_nx    = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        pc_nx    = '0;
        ct_nx    = '0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      InstAddress <= '0;
      CycleCt     <= '0;
      Running     <= 1'b0;
      Done        <= 1'b0;
    end else begin
      InstAddress <= pc_nx;
      CycleCt     <= ct_nx;
      Running     <= (state_nx == S_RUN);
      Done        <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Randomized and directed bench for fetch_pc against a behavioural model.
module tb_fetch_pc;

  localparam int unsigned A   = 10;
  localparam int unsigned OW  = 8;
  localparam int unsigned CW  = 16;
  localparam int          PCN = 1 << A;
  localparam int          CTMAX  = (1 << CW) - 1;
  localparam int          CTMAX4 = 15;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic          Clk = 1'b0;
  logic          Reset, Start, Halt, Stall, Taken, AbsSel;
  logic [A-1:0]  Target;
  logic [OW-1:0] RelOff;
  logic [A-1:0]  InstAddress, InstAddress4;
  logic          Running, Done, Running4, Done4;
  logic [CW-1:0] CycleCt;
  logic [3:0]    CycleCt4;

  int n_chk  = 0;
  int n_pass = 0;

  int m_st, m_pc, m_ct, m_ct4;

  always #5 Clk = ~Clk;

  fetch_pc #(.A(A), .OW(OW), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Taken(Taken), .AbsSel(AbsSel), .Target(Target), .RelOff(RelOff),
    .InstAddress(InstAddress), .Running(Running), .Done(Done), .CycleCt(CycleCt)
  );

  fetch_pc #(.A(A), .OW(OW), .CW(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Taken(Taken), .AbsSel(AbsSel), .Target(Target), .RelOff(RelOff),
    .InstAddress(InstAddress4), .Running(Running4), .Done(Done4), .CycleCt(CycleCt4)
  );

  task automatic model_restart();
    m_st  = M_ARMED;
    m_pc  = 0;
    m_ct  = 0;
    m_ct4 = 0;
  endtask

  // Advance the reference model by one edge using the current inputs.
  task automatic model_edge();
    if (!Reset) begin
      m_st = M_IDLE; m_pc = 0; m_ct = 0; m_ct4 = 0;
    end else if (m_st == M_IDLE) begin
      if (Start) model_restart();
    end else if (m_st == M_ARMED) begin
      m_pc = 0;
      if (!Start) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (Start) model_restart();
      else begin
        if (m_ct < CTMAX) m_ct = m_ct + 1;
        if (m_ct4 < CTMAX4) m_ct4 = m_ct4 + 1;
        if (Halt) m_st = M_DONE;
        else if (Stall) m_pc = m_pc;
        else if (Taken && AbsSel) m_pc = int'(Target);
        else if (Taken) m_pc = (m_pc + int'($signed(RelOff)) + PCN) % PCN;
        else m_pc = (m_pc + 1) % PCN;
      end
    end else begin
      if (Start) model_restart();
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 0; Halt = 0; Stall = 0; Taken = 0; AbsSel = 0;
    Target = '0; RelOff = '0;
  endtask

  task automatic launch();
    Start = 1; tick(); tick();
    Start = 0; tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 0; Start = 1; Halt = 1;
    tick(); tick();
    n_chk++;
    if ({InstAddress, Running, Done, CycleCt} !== '0)
      $display("FAIL reset_outputs pc=%0d run=%0b done=%0b ct=%0d expected all zero",
               InstAddress, Running, Done, CycleCt);
    else n_pass++;
    n_chk++;
    if ({InstAddress4, Running4, Done4, CycleCt4} !== '0)
      $display("FAIL reset_outputs_cw4 pc=%0d ct=%0d expected zero", InstAddress4, CycleCt4);
    else n_pass++;
    idle_inputs();
    Reset = 1;
    tick();
    n_chk++;
    if (Running !== 1'b0 || InstAddress !== '0)
      $display("FAIL reset_release_idle run=%0b pc=%0d expected 0/0", Running, InstAddress);
    else n_pass++;
  endtask

  task automatic test_launch();
    Start = 1; tick(); tick();
    n_chk++;
    if (Running !== 1'b0 || InstAddress !== '0 || CycleCt !== '0)
      $display("FAIL armed_hold run=%0b pc=%0d ct=%0d expected 0/0/0", Running, InstAddress, CycleCt);
    else n_pass++;
    Start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (InstAddress !== A'(i) || Running !== 1'b1 || InstAddress !== A'(m_pc))
        $display("FAIL launch_seq step=%0d pc=%0d run=%0b expected pc=%0d run=1",
                 i, InstAddress, Running, i);
      else n_pass++;
    end
    tick(); tick();
  endtask

  task automatic test_halt();
    n_chk++;
    if (InstAddress !== A'(5))
      $display("FAIL halt_setup pc=%0d expected 5", InstAddress);
    else n_pass++;
    Halt = 1; Taken = 1; Stall = 1; AbsSel = 1; Target = A'(99);
    tick();
    n_chk++;
    if (Done !== 1'b1 || Running !== 1'b0 || InstAddress !== A'(5) || CycleCt !== CW'(6))
      $display("FAIL halt_priority done=%0b run=%0b pc=%0d ct=%0d expected 1/0/5/6",
               Done, Running, InstAddress, CycleCt);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      Halt = 1'($urandom); Stall = 1'($urandom); Taken = 1'($urandom);
      AbsSel = 1'($urandom); Target = A'($urandom); RelOff = OW'($urandom);
      tick();
      n_chk++;
      if (InstAddress !== A'(5) || Done !== 1'b1 || CycleCt !== CW'(6))
        $display("FAIL done_hold cyc=%0d pc=%0d done=%0b ct=%0d expected 5/1/6",
                 i, InstAddress, Done, CycleCt);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_branches();
    launch();
    Taken = 1; AbsSel = 1; Target = A'(20); tick();
    AbsSel = 0; RelOff = 8'hFC; tick();
    n_chk++;
    if (InstAddress !== A'(16) || InstAddress !== A'(m_pc))
      $display("FAIL rel_branch pc=%0d expected 16", InstAddress);
    else n_pass++;
    AbsSel = 1; Target = A'(700); tick();
    n_chk++;
    if (InstAddress !== A'(700))
      $display("FAIL abs_branch pc=%0d expected 700", InstAddress);
    else n_pass++;
    Target = A'(3); tick();
    AbsSel = 0; RelOff = 8'hFC; tick();
    n_chk++;
    if (InstAddress !== A'(1023))
      $display("FAIL rel_wrap pc=%0d expected 1023", InstAddress);
    else n_pass++;
    Taken = 0;
  endtask

  task automatic test_stall_wrap();
    logic [CW-1:0] ct0;
    ct0 = CycleCt;
    Stall = 1;
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (InstAddress !== A'(1023) || CycleCt !== ct0 + CW'(3))
      $display("FAIL stall_hold pc=%0d ct=%0d expected 1023/%0d", InstAddress, CycleCt, ct0 + CW'(3));
    else n_pass++;
    Stall = 0; tick();
    n_chk++;
    if (InstAddress !== '0 || CycleCt !== CW'(m_ct))
      $display("FAIL pc_wrap pc=%0d ct=%0d expected 0/%0d", InstAddress, CycleCt, m_ct);
    else n_pass++;
  endtask

  task automatic test_restart();
    Halt = 1; tick();
    Halt = 0; Start = 1; tick();
    n_chk++;
    if (Done !== 1'b0 || CycleCt !== '0 || Running !== 1'b0 || InstAddress !== '0)
      $display("FAIL restart_armed done=%0b ct=%0d run=%0b pc=%0d expected 0/0/0/0",
               Done, CycleCt, Running, InstAddress);
    else n_pass++;
    Start = 0; tick(); tick();
    n_chk++;
    if (Running !== 1'b1 || InstAddress !== A'(1) || CycleCt !== CW'(1))
      $display("FAIL restart_run run=%0b pc=%0d ct=%0d expected 1/1/1", Running, InstAddress, CycleCt);
    else n_pass++;
    Taken = 1; AbsSel = 1; Target = A'(40); tick();
    Taken = 0;
    Reset = 0; Start = 1; Halt = 1; tick();
    n_chk++;
    if ({InstAddress, Running, Done, CycleCt} !== '0)
      $display("FAIL reset_midrun pc=%0d run=%0b done=%0b ct=%0d expected zeros",
               InstAddress, Running, Done, CycleCt);
    else n_pass++;
    Reset = 1; Start = 0; Halt = 0; tick();
    n_chk++;
    if (Running !== 1'b0 || InstAddress !== '0)
      $display("FAIL reset_to_idle run=%0b pc=%0d expected 0/0", Running, InstAddress);
    else n_pass++;
  endtask

  task automatic test_saturation();
    idle_inputs();
    launch();
    for (int i = 0; i < 20; i++) tick();
    n_chk++;
    if (CycleCt4 !== 4'd15 || CycleCt !== CW'(20))
      $display("FAIL counter_saturate ct4=%0d ct=%0d expected 15/20", CycleCt4, CycleCt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      Reset  = ($urandom_range(0, 199) != 0);
      Start  = ($urandom_range(0, 99) < 4);
      Halt   = ($urandom_range(0, 99) < 3);
      Stall  = ($urandom_range(0, 99) < 20);
      Taken  = ($urandom_range(0, 99) < 25);
      AbsSel = 1'($urandom);
      Target = A'($urandom);
      RelOff = OW'($urandom);
      tick();
      n_chk++;
      if (InstAddress !== A'(m_pc) || CycleCt !== CW'(m_ct) ||
          Running !== (m_st == M_RUN) || Done !== (m_st == M_DONE) ||
          InstAddress4 !== A'(m_pc) || CycleCt4 !== 4'(m_ct4))
        $display("FAIL random_cycle i=%0d pc=%0d ct=%0d run=%0b done=%0b ct4=%0d expected pc=%0d ct=%0d st=%0d ct4=%0d",
                 i, InstAddress, CycleCt, Running, Done, CycleCt4, m_pc, m_ct, m_st, m_ct4);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    Reset = 0;
    m_st = M_IDLE; m_pc = 0; m_ct = 0; m_ct4 = 0;
    @(posedge Clk); #1;
    test_reset();
    test_launch();
    test_halt();
    test_branches();
    test_stall_wrap();
    test_restart();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter and fetch sequencer for the 9-bit ISA core. Sits directly upstream of the instruction ROM: its registered `InstAddress` drives the ROM address input, and it consumes decoded halt/branch information about the instruction currently on the ROM output. It also arms and launches a program run on the `Start` handshake, signals `Done` at halt, and counts executed cycles.

## Interface
Parameters:
- `A`, default 10: PC / instruction address width, matching the ROM's `A`.
- `OW`, default 8: relative branch offset width (two's complement).
- `CW`, default 16: cycle counter width.

Ports:
- `Clk`  in  1  sole clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `Clk`.
- `Start`  in  1  run handshake from the testbench or top level.
- `Halt`  in  1  current instruction is halt (combinational decode of ROM output).
- `Stall`  in  1  hold PC this cycle.
- `Taken`  in  1  current instruction redirects the PC.
- `AbsSel`  in  1  when `Taken`: 1 = absolute target, 0 = relative offset.
- `Target`  in  A  absolute branch target.
- `RelOff`  in  OW  signed PC-relative offset.
- `InstAddress`  out  A  registered PC, drives the ROM address.
- `Running`  out  1  high in RUN.
- `Done`  out  1  high in DONE.
- `CycleCt`  out  CW  RUN cycles of the current or last program.

## Operation
- States: IDLE, ARMED, RUN, DONE. All outputs are registered, or decoded directly from the state register.
- On reset (`Reset`=0 at an edge): state IDLE, `InstAddress`=0, `CycleCt`=0, `Running`=0, `Done`=0. Reset overrides every other input.
- IDLE:
  - `Start`=1 → ARMED, with PC=0 and `CycleCt`=0.
  - Otherwise hold.
- ARMED:
  - PC held at 0.
  - `Start`=0 → RUN. Launch happens on the falling side of the handshake.
  - `Start`=1 → stay in ARMED.
- RUN: each edge applies the first matching rule, in this priority order.
  1. `Start`=1 → ARMED, PC=0, `CycleCt`=0 (restart).
  2. `Halt`=1 → DONE, PC holds. Halt beats `Stall` and `Taken`.
  3. `Stall`=1 → PC holds.
  4. `Taken`=1 and `AbsSel`=1 → PC=`Target`.
  5. `Taken`=1 and `AbsSel`=0 → PC = PC + sign-extend(`RelOff`), truncated to A bits (mod 2^A).
  6. Otherwise → PC = PC+1 mod 2^A. The PC wraps from 2^A−1 to 0 with no flag.
- `CycleCt` increments on every RUN edge, including stall edges and the halting edge. It saturates at all-ones with no wrap, and holds outside RUN.
- DONE:
  - PC and `CycleCt` hold; `Done`=1.
  - `Start`=1 → ARMED (PC=0, `CycleCt`=0, `Done` drops).
- `Halt`, `Stall`, `Taken`, `AbsSel`, `Target` and `RelOff` are ignored outside RUN.

## Timing
- PC-to-instruction latency is zero extra cycles: the ROM is combinational, so the instruction for `InstAddress` is valid in the same cycle and its decode acts at the next edge.
- Sequential fetch throughput is one instruction per cycle.
- Branch redirect:
  - The new PC appears one edge after `Taken` is sampled.
  - There is no delay slot and no bubble.
- `Done` rises on the same edge that samples `Halt`=1 in RUN; `Running` falls on that edge.
- Start handshake, counting edges from IDLE:
  - Raising `Start` takes effect at the next edge (IDLE→ARMED).
  - The first edge with `Start`=0 enters RUN, with `InstAddress`=0.
  - Address 0 is fetched in the first RUN cycle.
- Reset mid-run takes effect at that edge regardless of `Start` or `Halt`. The next state is IDLE, not ARMED.

## Test plan
- **Reset then launch:** hold `Reset`=0 for 2 edges, then `Reset`=1; pulse `Start` 1 for 2 cycles, then 0; drive `Halt`=0 → `InstAddress` reads 0,1,2,3 on successive RUN cycles; `Running`=1.
- **Halt priority:** PC=5 with `Halt`=1, `Taken`=1, `Stall`=1 → next edge gives `Done`=1 and `InstAddress`=5; `CycleCt` equals the number of RUN edges so far; PC stays 5 for 10 more cycles.
- **Branches:**
  - PC=20, `Taken`=1, `AbsSel`=0, `RelOff`=8'hFC (−4) → PC=16.
  - PC=16, `AbsSel`=1, `Target`=700 → PC=700.
  - PC=3, `RelOff`=−4 → PC=1023 (wrap).
- **Stall and wrap:** PC=1023 with `Stall`=1 for 3 cycles → PC stays 1023 and `CycleCt` advances by 3; release → PC=0.
- **Restart and reset:**
  - In DONE, raise `Start` → ARMED, `Done`=0, `CycleCt`=0; drop `Start` → a RUN from 0 follows.
  - In RUN at PC=40, drive `Reset`=0 → next edge gives IDLE with all outputs 0.
- **Counter saturation:** with `CW` overridden to 4, run 20 cycles without halt → `CycleCt` sticks at 15.
